// File: rtl/raxi_pkg.sv
// raxi_pkg: shared types and constants for the rAXI stream receiver.
//   raxi_fsm_t  - framing state (idle / inside a frame)
//   RAXI_FLAGS  - number of per-beat flag bits carried through the FIFO
//                 (first, last, keep)
package raxi_pkg;

    typedef enum logic {RAXI_IDLE, RAXI_IN_FRAME} raxi_fsm_t;

    localparam int RAXI_FLAGS = 3;

endpackage

// File: rtl/raxi_fifo.sv
// raxi_fifo: generic first-word-fall-through FIFO with asynchronous reset.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   wr_en, din      - write request and data (ignored while full)
//   rd_en, dout     - pop request (ignored while empty); dout = head entry
//   full, empty     - decoded from the registered occupancy count
// Storage is cleared on reset so dout reads as zero until written.
module raxi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Write is blocked while full even if a pop happens in the same cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/raxi_rx.sv
// raxi_rx: rAXI stream receiver. Accepts beats on s_valid & s_ready into a
// DEPTH-entry FWFT FIFO, presents them on the o_* port, and checks frame
// structure (first / last / id consistency).
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   s_valid/s_ready, s_*     - input beat handshake and payload
//   o_valid/o_ready, o_*     - buffered output beat handshake and payload
//   err_nofirst              - pulse: beat outside a frame without first
//   err_nolast               - pulse: first seen inside an open frame
//   err_id                   - pulse: id changed inside a frame
//   frm_cnt                  - completed-frame count (wraps)
// Optional feature macro: RAXI_RX_DROP_EN - when defined, orphan beats
// (first=0 while idle) are consumed but not stored and do not count frames.
module raxi_rx
    import raxi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int UW    = 8,
    parameter int IW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic          s_first,
    input  logic          s_last,
    input  logic          s_keep,
    input  logic [DW-1:0] s_data,
    input  logic [UW-1:0] s_user,
    input  logic [IW-1:0] s_id,
    output logic          s_ready,
    output logic          o_valid,
    output logic          o_first,
    output logic          o_last,
    output logic          o_keep,
    output logic [DW-1:0] o_data,
    output logic [UW-1:0] o_user,
    output logic [IW-1:0] o_id,
    input  logic          o_ready,
    output logic          err_nofirst,
    output logic          err_nolast,
    output logic          err_id,
    output logic [CW-1:0] frm_cnt
);

    localparam int W = RAXI_FLAGS + IW + UW + DW;

    raxi_fsm_t     state, state_nx;
    logic [IW-1:0] id_q, id_nx;
    logic [CW-1:0] cnt_nx;
    logic          nofirst_nx, nolast_nx, id_err_nx;
    logic          full, empty, accept, store, pop;
    logic [W-1:0]  din, dout;

    assign s_ready = ~full;
    assign o_valid = ~empty;
    assign accept  = s_valid & s_ready;
    assign pop     = o_valid & o_ready;
    assign din     = {s_first, s_last, s_keep, s_id, s_user, s_data};
    assign {o_first, o_last, o_keep, o_id, o_user, o_data} = dout;

    raxi_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (store),
        .din   (din),
        .rd_en (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx   = state;
        id_nx      = id_q;
        cnt_nx     = frm_cnt;
        nofirst_nx = 1'b0;
        nolast_nx  = 1'b0;
        id_err_nx  = 1'b0;
        store      = accept;
        if (accept) begin
            case (state)
                RAXI_IDLE: begin
                    if (s_first) begin
                        id_nx    = s_id;
                        state_nx = s_last ? RAXI_IDLE : RAXI_IN_FRAME;
                        if (s_last) cnt_nx = frm_cnt + CW'(1);
                    end else begin
                        nofirst_nx = 1'b1;
`ifdef RAXI_RX_DROP_EN
                        // Orphan is swallowed: handshake completes, nothing stored.
                        store = 1'b0;
`else
                        // Orphan is treated as an implicit frame start.
                        id_nx    = s_id;
                        state_nx = s_last ? RAXI_IDLE : RAXI_IN_FRAME;
                        if (s_last) cnt_nx = frm_cnt + CW'(1);
`endif
                    end
                end
                RAXI_IN_FRAME: begin
                    id_err_nx = (s_id != id_q);
                    id_nx     = s_id;
                    // A first here restarts the frame; last still closes it.
                    nolast_nx = s_first;
                    if (s_last) begin
                        state_nx = RAXI_IDLE;
                        cnt_nx   = frm_cnt + CW'(1);
                    end
                end
                default: state_nx = RAXI_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RAXI_IDLE;
            id_q        <= '0;
            frm_cnt     <= '0;
            err_nofirst <= 1'b0;
            err_nolast  <= 1'b0;
            err_id      <= 1'b0;
        end else begin
            state       <= state_nx;
            id_q        <= id_nx;
            frm_cnt     <= cnt_nx;
            err_nofirst <= nofirst_nx;
            err_nolast  <= nolast_nx;
            err_id      <= id_err_nx;
        end
    end

endmodule

// File: doc/raxi_rx.md
Name: raxi_rx

Overview:
- rAXI stream receiver (responder end): drives ready, accepts beats on valid&ready, buffers them in a DEPTH-entry FIFO.
- Presents the buffered beats first-word-fall-through on an output rAXI port with its own valid/ready.
- Checks frame structure (first/last/id) and reports protocol errors.
- Sits at the sink end of any rAXI link, e.g. in front of DSP blocks that cannot absorb back-to-back beats.

Parameters:
- DW, 8, data width
- UW, 8, user width
- IW, 8, id width
- DEPTH, 8, FIFO entries; power of 2, >=2
- CW, 16, frame counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input beat valid
- s_first  in  1  first beat of frame
- s_last  in  1  last beat of frame
- s_keep  in  1  beat keep flag (stored, not interpreted)
- s_data  in  DW  beat data
- s_user  in  UW  beat user
- s_id  in  IW  beat id
- s_ready  out  1  receiver can accept
- o_valid  out  1  output beat valid
- o_first / o_last / o_keep  out  1 each  buffered flags
- o_data  out  DW  buffered data
- o_user  out  UW  buffered user
- o_id  out  IW  buffered id
- o_ready  in  1  downstream pop
- err_nofirst  out  1  pulse: frame started without first
- err_nolast  out  1  pulse: first seen inside open frame
- err_id  out  1  pulse: id changed inside frame
- frm_cnt  out  CW  completed-frame count

Behaviour:
- Interface is one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values:
  - count=0, read/write pointers 0, so s_ready=1 and o_valid=0.
  - o_* data and flags 0.
  - All err_* 0, frm_cnt 0, FSM in IDLE.
- Handshakes:
  - Accept: s_valid & s_ready. Pop: o_valid & o_ready.
  - s_ready = (count != DEPTH), decoded from the registered count.
  - o_valid = (count != 0).
  - o_* = mem[rd_ptr], combinational from storage.
- Latency: a beat accepted at edge N appears on o_* after edge N; no same-cycle bypass when the FIFO is empty.
- Full: s_ready=0 even if a pop happens in the same cycle; no write-through.
- Simultaneous accept and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers are AW=$clog2(DEPTH) bits and wrap modulo DEPTH.
- Source holding valid while ready=0 is legal; nothing is sampled.
- Framing FSM advances on accepted beats only. IDLE:
  - first&last -> IDLE; frm_cnt+1.
  - first&!last -> IN_FRAME; latch id.
  - !first -> err_nofirst pulse; latch id. Goes to IN_FRAME if !last; if last, stays IDLE and frm_cnt+1.
- Framing FSM, IN_FRAME:
  - s_id != latched id -> err_id pulse; latch the new id.
  - first -> err_nolast pulse; restart the frame with the new id (IN_FRAME if !last, else IDLE with frm_cnt+1).
  - last -> IDLE; frm_cnt+1.
- Errors:
  - Each err_* is a registered 1-cycle pulse in the cycle after the offending accept.
  - Several err_* may pulse together.
- frm_cnt wraps 2^CW-1 -> 0.
- Reset mid-frame or mid-burst: FIFO contents are discarded and the FSM returns to IDLE immediately, asynchronously.

Optional Feature:
- Macro: RAXI_RX_DROP_EN.
- Defined: a beat accepted in IDLE with first=0 is consumed (handshake completes) but not written to the FIFO. err_nofirst still pulses. FSM stays IDLE and frm_cnt is unchanged. Orphan beats with the same condition in later cycles are also dropped until a first arrives.
- Undefined: orphan beats are stored and handled as in Behaviour.

Decomposition:
- Package raxi_pkg holds:
  - typedef enum logic {RAXI_IDLE, RAXI_IN_FRAME} raxi_fsm_t
  - localparam RAXI_FLAGS=3 (first, last, keep)
- Sub-module raxi_fifo (parameters WIDTH, DEPTH):
  - Generic FWFT storage: wr_en/din, rd_en/dout, full, empty; async reset.
  - raxi_rx packs {first,last,keep,id,user,data} into WIDTH=3+IW+UW+DW.
- FSM, id latch, error pulses and counter stay in raxi_rx.

Test Plan:
- Reset, then a 4-beat frame id=3, data 1..4, o_ready=1: o_valid rises the cycle after the first accept; o_data 1,2,3,4 in order; o_first on beat 1 and o_last on beat 4; frm_cnt=1; no errors.
- DEPTH=8, o_ready=0, source always valid: exactly 8 beats accepted, then s_ready=0. Raise o_ready for 1 cycle: s_ready returns the next cycle and data order is preserved.
- Single-beat frames first=last=1 for 10 cycles: frm_cnt=10, FSM stays IDLE, no errors.
- Beat with first=0 after reset, then last=1: err_nofirst pulses once and frm_cnt=1. With RAXI_RX_DROP_EN, 0 beats appear on o_* and frm_cnt=0.
- In-frame id changes 5 -> 6: err_id pulses one cycle. A first mid-frame gives err_nolast and the frame restarts.
- CW=4: 17 frames give frm_cnt=1. Reset asserted mid-frame with count=5: o_valid=0 and s_ready=1 at once, and the following frame has no spurious errors.
